// File: rtl/vga_block_scanner.sv
// vga_block_scanner
// Display-side reader of the block pixel interface. Generates VGA raster
// timing, converts the raster position into block coordinates for the
// graphics controller, samples the 8-bit packed colour the controller
// returns combinationally, and drives the VGA colour and sync pins. Also
// provides the per-frame buffer-select toggle (whichRAM).
//
// Ports:
//   clk                       system clock
//   reset                     asynchronous assert, synchronous release, active-low
//   x_coord_of_current_block  block column, left = 0 (held during blanking)
//   y_coord_of_current_block  block row, bottom = 0 (held during blanking)
//   pixelPacking_in           colour from controller: [2:0] red, [5:3] green, [7:6] blue
//   vga_r / vga_g / vga_b     colour to DAC, forced to 0 outside the active region
//   vga_hs / vga_vs           syncs, active-low
//   frame_start               one-clk pulse on the first active pixel tick of a frame
//   whichRAM                  toggles at every frame_start
//
// Optional feature: define VGA_GRID_OVERLAY_EN to blank the first pixel
// column and first line of every block (one-pixel black grid).
module vga_block_scanner #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int BLOCK_SIZE = 20
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x_coord_of_current_block,
  output logic [9:0] y_coord_of_current_block,
  input  logic [7:0] pixelPacking_in,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_start,
  output logic       whichRAM
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] B_LAST  = BW'(BLOCK_SIZE - 1);
  localparam logic [9:0]    ROW_TOP = 10'(V_ACTIVE / BLOCK_SIZE - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [BW-1:0] hx;
  logic [BW-1:0] vy;
  logic [9:0]    column;
  logic [9:0]    row;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic          frame_tick;
  logic          active_d;
  logic          hs_d;
  logic          vs_d;
  logic          blank;

  assign tick       = (presc == P_LAST);
  assign h_wrap     = (h_cnt == H_LAST);
  assign v_wrap     = (v_cnt == V_LAST);
  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_raw     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign frame_tick = tick && (h_cnt == '0) && (v_cnt == '0);

  // Pixel-rate prescaler; tick is high on the clk where it wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Block position tracked with sub-counters instead of dividing h/v by the
  // block size. They only advance inside the active area so the column/row
  // never run far past the last block during blanking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hx     <= '0;
      column <= '0;
      vy     <= '0;
      row    <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        hx     <= '0;
        column <= '0;
      end else if (h_cnt < H_ACT) begin
        if (hx == B_LAST) begin
          hx     <= '0;
          column <= column + 1'b1;
        end else begin
          hx <= hx + 1'b1;
        end
      end
      if (h_wrap) begin
        if (v_wrap) begin
          vy  <= '0;
          row <= '0;
        end else if (v_cnt < V_ACT) begin
          if (vy == B_LAST) begin
            vy  <= '0;
            row <= row + 1'b1;
          end else begin
            vy <= vy + 1'b1;
          end
        end
      end
    end
  end

  // Stage 1: coordinates to the controller (bottom-origin rows), plus the
  // active flag and syncs delayed alongside them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_coord_of_current_block <= '0;
      y_coord_of_current_block <= ROW_TOP;
      active_d                 <= 1'b0;
      hs_d                     <= 1'b1;
      vs_d                     <= 1'b1;
    end else if (tick) begin
      active_d <= active;
      hs_d     <= hs_raw;
      vs_d     <= vs_raw;
      if (active) begin
        x_coord_of_current_block <= column;
        y_coord_of_current_block <= ROW_TOP - row;
      end
    end
  end

`ifdef VGA_GRID_OVERLAY_EN
  logic edge_d;

  // Remember whether this pixel sits on a block's first column or line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    edge_d <= 1'b0;
    else if (tick) edge_d <= (hx == '0) || (vy == '0);
  end

  assign blank = !active_d || edge_d;
`else
  assign blank = !active_d;
`endif

  // Stage 2: sample the controller's colour and keep syncs aligned with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {vga_b, vga_g, vga_r} <= '0;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
    end else if (tick) begin
      vga_hs <= hs_d;
      vga_vs <= vs_d;
      if (blank) {vga_b, vga_g, vga_r} <= '0;
      else       {vga_b, vga_g, vga_r} <= pixelPacking_in;
    end
  end

  // Frame marker and double-buffer select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      whichRAM    <= 1'b0;
    end else begin
      frame_start <= frame_tick;
      if (frame_tick) whichRAM <= ~whichRAM;
    end
  end

endmodule
